// File: rtl/sprite_rom_arbiter_if.sv
// rtl/sprite_rom_arbiter_if.sv - requester and ROM bus of the sprite ROM arbiter
interface sprite_rom_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 2
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic [ADDR_W-1:0]         rom_addr;
  logic                      rom_en;
  logic [DATA_W-1:0]         rom_q;

  modport slave (
    input  req, addr, rom_q,
    output grant, rvalid, rdata, rom_addr, rom_en
  );

  modport master (
    output req, addr, rom_q,
    input  grant, rvalid, rdata, rom_addr, rom_en
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - round-robin sharing of one sprite ROM with tagged return path
// Optional macro SPRITE_ROM_ARB_PRIORITY_EN: requester 0 gets fixed absolute priority.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 2,
  parameter int ROM_LAT = 1
) (
  input  logic                 vga_clk,
  input  logic                 reset,
  sprite_rom_arbiter_if.slave  bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef SPRITE_ROM_ARB_PRIORITY_EN
  localparam int RR_BASE = 1;
`else
  localparam int RR_BASE = 0;
`endif
  localparam int RR_N = NUM_REQ - RR_BASE;

  logic [PTR_W-1:0]   last_q, last_d;
  logic [NUM_REQ-1:0] grant_d;
  logic [ADDR_W-1:0]  win_addr;
  logic [ADDR_W-1:0]  addr_a [NUM_REQ];
  logic [NUM_REQ-1:0] tag_q [ROM_LAT+1];
  logic [ADDR_W-1:0]  rom_addr_q;
  logic               rom_en_q;
  logic [NUM_REQ-1:0] rvalid_q;
  logic [DATA_W-1:0]  rdata_q;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_a[i] = bus.addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Search the round-robin ring starting just after the last winner.
  always_comb begin
    logic             found;
    int               idx_int;
    logic [PTR_W-1:0] idx;
    grant_d  = '0;
    last_d   = last_q;
    win_addr = '0;
    found    = 1'b0;
    idx_int  = 0;
    idx      = '0;
    if (!reset) begin
`ifdef SPRITE_ROM_ARB_PRIORITY_EN
      if (bus.req[0]) begin
        found      = 1'b1;
        grant_d[0] = 1'b1;
        win_addr   = addr_a[0];
      end
`endif
      for (int k = 1; k <= RR_N; k++) begin
        idx_int = ((int'(last_q) - RR_BASE + k) % RR_N) + RR_BASE;
        idx     = PTR_W'(idx_int);
        if (!found && bus.req[idx]) begin
          found        = 1'b1;
          grant_d[idx] = 1'b1;
          last_d       = idx;
          win_addr     = addr_a[idx];
        end
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      last_q     <= PTR_W'(NUM_REQ - 1);
      rom_addr_q <= '0;
      rom_en_q   <= 1'b0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      for (int j = 0; j <= ROM_LAT; j++) begin
        tag_q[j] <= '0;
      end
    end else begin
      last_q   <= last_d;
      rom_en_q <= |grant_d;
      if (|grant_d) begin
        rom_addr_q <= win_addr;
      end
      tag_q[0] <= grant_d;
      for (int j = 1; j <= ROM_LAT; j++) begin
        tag_q[j] <= tag_q[j-1];
      end
      // Tail tag lines up with the cycle rom_q carries this read's word.
      rvalid_q <= tag_q[ROM_LAT];
      if (|tag_q[ROM_LAT]) begin
        rdata_q <= bus.rom_q;
      end
    end
  end

  assign bus.grant    = grant_d;
  assign bus.rvalid   = rvalid_q;
  assign bus.rdata    = rdata_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.rom_en   = rom_en_q;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - self-checking bench for sprite_rom_arbiter
// Honours SPRITE_ROM_ARB_PRIORITY_EN the same way the design does.
module tb_sprite_rom_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 2;
  localparam int ROM_LAT = 1;
  localparam int LAT     = ROM_LAT + 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  sprite_rom_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sprite_rom_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)
  ) dut (
    .vga_clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] rom_word(logic [7:0] a);
    return a[1:0] ^ a[3:2] ^ a[7:6];
  endfunction

  always @(posedge clk) bus.rom_q <= rom_word(bus.rom_addr);

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: who must win this cycle, given the last winner.
  function automatic int model_winner(logic [3:0] r, int last);
`ifdef SPRITE_ROM_ARB_PRIORITY_EN
    if (r[0]) return 0;
    for (int k = 1; k < NUM_REQ; k++) begin
      int i;
      i = 1 + ((last - 1 + k) % (NUM_REQ - 1));
      if (r[i]) return i;
    end
`else
    for (int k = 1; k <= NUM_REQ; k++) begin
      int i;
      i = (last + k) % NUM_REQ;
      if (r[i]) return i;
    end
`endif
    return -1;
  endfunction

  typedef struct {
    int         due;
    logic [3:0] tag;
    logic [1:0] data;
  } ret_t;

  ret_t       pend[$];
  int         m_last = NUM_REQ - 1;
  logic [7:0] m_rom_addr = '0;
  logic       m_rom_en = 1'b0;
  logic [1:0] m_rdata = '0;
  bit         armed = 1'b0;

  always @(negedge clk) begin : cmp
    int         w;
    logic [3:0] eg;
    logic [3:0] erv;
    logic [7:0] sl;
    w  = reset ? -1 : model_winner(bus.req, m_last);
    eg = (w >= 0) ? (4'b0001 << w) : 4'b0000;
    check("grant", bus.grant, eg);
    if (armed) begin
      erv = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        erv     = pend[0].tag;
        m_rdata = pend[0].data;
        void'(pend.pop_front());
      end
      check("rvalid", bus.rvalid, erv);
      check("rdata", bus.rdata, m_rdata);
      check("rom_en", bus.rom_en, m_rom_en);
      check("rom_addr", bus.rom_addr, m_rom_addr);
    end
    if (reset) begin
      m_last     = NUM_REQ - 1;
      pend.delete();
      m_rom_addr = '0;
      m_rom_en   = 1'b0;
      m_rdata    = '0;
      armed      = 1'b1;
    end else if (w >= 0) begin
      sl = bus.addr[w*ADDR_W +: ADDR_W];
`ifdef SPRITE_ROM_ARB_PRIORITY_EN
      if (w != 0) m_last = w;
`else
      m_last = w;
`endif
      m_rom_addr = sl;
      m_rom_en   = 1'b1;
      pend.push_back('{cyc + LAT, eg, rom_word(sl)});
    end else begin
      m_rom_en = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_g [6];
  logic [1:0] exp_d [4];
  logic [3:0] seen_g [6];
  int         waited;

  initial begin
    bus.req  = '0;
    bus.addr = {8'h40, 8'h31, 8'h22, 8'h13};
    repeat (3) tick();
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick();
      #1;
      check("idle_grant", bus.grant, 4'b0000);
      check("idle_rvalid", bus.rvalid, 4'b0000);
      check("idle_rom_en", bus.rom_en, 1'b0);
      check("idle_rom_addr", bus.rom_addr, 8'h00);
    end

    tick();
    bus.addr[2*ADDR_W +: ADDR_W] = 8'h37;
    bus.req = 4'b0100;
    #1;
    check("single_grant", bus.grant, 4'b0100);
    tick();
    bus.req = 4'b0000;
    #1;
    check("single_rom_addr", bus.rom_addr, 8'h37);
    check("single_rom_en", bus.rom_en, 1'b1);
    tick();
    tick();
    #1;
    check("single_rvalid", bus.rvalid, 4'b0100);
    check("single_rdata", bus.rdata, 2'b10);

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    bus.addr = {8'h40, 8'h31, 8'h22, 8'h13};
    exp_d = '{2'b11, 2'b10, 2'b01, 2'b01};
`ifdef SPRITE_ROM_ARB_PRIORITY_EN
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
`endif
    for (int t = 0; t < 9; t++) begin
      tick();
      bus.req = (t < 6) ? 4'b1111 : 4'b0000;
      #1;
      if (t < 6) begin
        seen_g[t] = bus.grant;
        check("rr_grant", bus.grant, exp_g[t]);
      end
      if (t >= 3) begin
        check("rr_rvalid", bus.rvalid, exp_g[t-3]);
        check("rr_rdata", bus.rdata, exp_d[$clog2(exp_g[t-3])]);
      end
    end

    for (int t = 0; t < 2; t++) begin
      tick();
      bus.req = 4'b0010;
      #1;
      check("fair_busy", |bus.grant, 1'b1);
    end
    waited = 0;
    tick();
    bus.req = 4'b1010;
    #1;
    while (!bus.grant[3] && waited < 4) begin
      check("fair_busy", |bus.grant, 1'b1);
      tick();
      waited++;
      #1;
    end
    check("fair_r3_latency_ok", (waited <= 2), 1'b1);
    tick();
    bus.req = 4'b0010;
    #1;
    check("fair_r1_resume", bus.grant, 4'b0010);
    tick();
    bus.req = 4'b0000;

    tick();
    bus.req = 4'b0011;
    tick();
    tick();
    bus.req = 4'b0000;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rst_grant", bus.grant, 4'b0000);
    check("rst_rvalid", bus.rvalid, 4'b0000);
    check("rst_rdata", bus.rdata, 2'b00);
    check("rst_rom_en", bus.rom_en, 1'b0);
    check("rst_rom_addr", bus.rom_addr, 8'h00);
    for (int t = 0; t < 4; t++) begin
      tick();
      #1;
      check("rst_no_rvalid", bus.rvalid, 4'b0000);
    end

`ifdef SPRITE_ROM_ARB_PRIORITY_EN
    for (int t = 0; t < 4; t++) begin
      tick();
      bus.req = 4'b1111;
      #1;
      check("prio_grant0", bus.grant, 4'b0001);
    end
    exp_g = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
    for (int t = 0; t < 3; t++) begin
      tick();
      bus.req = 4'b1110;
      #1;
      check("prio_rotate", bus.grant, exp_g[t]);
    end
    tick();
    bus.req = 4'b0000;
`endif

    repeat (6) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
